// File: rtl/cpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_fsm
//
// Multi-cycle control state machine for the 16-bit RISC datapath. Each state
// lasts one clock and owns every select and load enable of the datapath:
// register-file read mux, write-back mux, A/B/C/status/IR/PC/address register
// enables and the memory command.
//
// Ports
//   clk        rising-edge clock for all state
//   reset_n    asynchronous active-low reset (forces RST and its outputs)
//   opcode     IR[15:13]
//   op         IR[12:11]
//   nsel       one-hot register select   001=Rn 010=Rd 100=Rm
//   vsel       one-hot write-back select 0001=C 0010=PC 0100=sximm8 1000=mdata
//   write      register-file write enable
//   loada/b/c  A/B/C register enables
//   loads      status register enable
//   asel       1 forces ALU A input to 0
//   bsel       1 selects sximm5 for ALU B input
//   load_ir    instruction register enable
//   load_pc    program counter enable
//   reset_pc   selects 0 as next PC value
//   load_addr  data address register enable
//   addr_sel   1 selects PC as the memory address
//   mem_cmd    00=NONE 01=READ 10=WRITE
//   halted     high in the HALT state
//
// The outputs are a Moore function of the state. They are held in a register
// that is loaded with the decode of the *next* state on the same edge that
// loads the state register, so the registered outputs always match the
// current state with no extra cycle of latency. Both registers share the
// asynchronous reset, so write/mem_cmd/enables drop the moment reset_n falls.
// -----------------------------------------------------------------------------
module cpu_ctrl_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic [3:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    // -------------------------------------------------------------------------
    // Encodings
    // -------------------------------------------------------------------------
    typedef enum logic [4:0] {
        S_RST  = 5'd0,
        S_IF1  = 5'd1,
        S_IF2  = 5'd2,
        S_UPC  = 5'd3,
        S_DEC  = 5'd4,
        S_WIMM = 5'd5,
        S_GA   = 5'd6,
        S_GB   = 5'd7,
        S_ALUM = 5'd8,
        S_ALU  = 5'd9,
        S_CMPS = 5'd10,
        S_WRD  = 5'd11,
        S_ADDR = 5'd12,
        S_LA   = 5'd13,
        S_MRD  = 5'd14,
        S_WMEM = 5'd15,
        S_GBD  = 5'd16,
        S_PASS = 5'd17,
        S_MWR  = 5'd18,
        S_HALT = 5'd19
    } state_e;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    // {opcode, op} instruction codes
    localparam logic [4:0] I_MOVI = 5'b110_10;
    localparam logic [4:0] I_MOV  = 5'b110_00;
    localparam logic [4:0] I_ADD  = 5'b101_00;
    localparam logic [4:0] I_CMP  = 5'b101_01;
    localparam logic [4:0] I_AND  = 5'b101_10;
    localparam logic [4:0] I_MVN  = 5'b101_11;
    localparam logic [4:0] I_LDR  = 5'b011_00;
    localparam logic [4:0] I_STR  = 5'b100_00;

    typedef struct packed {
        logic [2:0] nsel;
        logic [3:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_t;

    // -------------------------------------------------------------------------
    // Output decode for a given state. Every state starts from the safe
    // defaults (Rn, C, no memory command, all enables off) so the selects are
    // always one-hot and nothing is enabled unless a state asks for it.
    // -------------------------------------------------------------------------
    function automatic ctrl_t ctrl_for(input state_e s);
        ctrl_t c;
        c         = '0;
        c.nsel    = NSEL_RN;
        c.vsel    = VSEL_C;
        c.mem_cmd = MEM_NONE;
        case (s)
            S_RST: begin
                c.reset_pc = 1'b1;
                c.load_pc  = 1'b1;
            end
            S_IF1: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
                c.load_ir  = 1'b1;
            end
            S_UPC: begin
                c.load_pc = 1'b1;
            end
            S_DEC: begin
                c.halted = 1'b0;
            end
            S_WIMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_IMM8;
                c.write = 1'b1;
            end
            S_GA: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            S_GB: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            S_ALUM: begin
                c.asel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_ALU: begin
                c.loadc = 1'b1;
            end
            S_CMPS: begin
                c.loads = 1'b1;
            end
            S_WRD: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            S_ADDR: begin
                c.bsel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_LA: begin
                c.load_addr = 1'b1;
            end
            S_MRD: begin
                c.mem_cmd = MEM_READ;
            end
            S_WMEM: begin
                c.mem_cmd = MEM_READ;
                c.nsel    = NSEL_RD;
                c.vsel    = VSEL_MDATA;
                c.write   = 1'b1;
            end
            S_GBD: begin
                c.nsel  = NSEL_RD;
                c.loadb = 1'b1;
            end
            S_PASS: begin
                c.asel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_MWR: begin
                c.mem_cmd = MEM_WRITE;
            end
            S_HALT: begin
                c.halted = 1'b1;
            end
            default: begin
                c.halted = 1'b0;
            end
        endcase
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_e     state_q;
    state_e     state_d;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_d;
    logic [4:0] instr_s;

    assign instr_s = {opcode, op};

    // Next-state logic; the IR is only consulted from DEC onward.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_IF1;
            S_IF1:  state_d = S_IF2;
            S_IF2:  state_d = S_UPC;
            S_UPC:  state_d = S_DEC;
            S_DEC: begin
                casez (instr_s)
                    I_MOVI:   state_d = S_WIMM;
                    I_MOV:    state_d = S_GB;
                    I_ADD:    state_d = S_GA;
                    I_CMP:    state_d = S_GA;
                    I_AND:    state_d = S_GA;
                    I_MVN:    state_d = S_GB;
                    I_LDR:    state_d = S_GA;
                    I_STR:    state_d = S_GA;
                    5'b111??: state_d = S_HALT;
                    default:  state_d = S_IF1;
                endcase
            end
            S_WIMM: state_d = S_IF1;
            S_GA: begin
                // Memory instructions compute Rn+sximm5; ALU ops fetch Rm next
                if ((instr_s == I_LDR) || (instr_s == I_STR)) begin
                    state_d = S_ADDR;
                end else begin
                    state_d = S_GB;
                end
            end
            S_GB: begin
                if ((instr_s == I_MOV) || (instr_s == I_MVN)) begin
                    state_d = S_ALUM;
                end else if (instr_s == I_CMP) begin
                    state_d = S_CMPS;
                end else begin
                    state_d = S_ALU;
                end
            end
            S_ALUM: state_d = S_WRD;
            S_ALU:  state_d = S_WRD;
            S_CMPS: state_d = S_IF1;
            S_WRD:  state_d = S_IF1;
            S_ADDR: state_d = S_LA;
            S_LA: begin
                if (instr_s == I_LDR) begin
                    state_d = S_MRD;
                end else begin
                    state_d = S_GBD;
                end
            end
            S_MRD:  state_d = S_WMEM;
            S_WMEM: state_d = S_IF1;
            S_GBD:  state_d = S_PASS;
            S_PASS: state_d = S_MWR;
            S_MWR:  state_d = S_IF1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Outputs for the state being entered, registered alongside it.
    always_comb begin
        ctrl_d = ctrl_for(state_d);
    end

    // State machine register with registered Moore outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RST;
            ctrl_q  <= ctrl_for(S_RST);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign nsel      = ctrl_q.nsel;
    assign vsel      = ctrl_q.vsel;
    assign write     = ctrl_q.write;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign load_ir   = ctrl_q.load_ir;
    assign load_pc   = ctrl_q.load_pc;
    assign reset_pc  = ctrl_q.reset_pc;
    assign load_addr = ctrl_q.load_addr;
    assign addr_sel  = ctrl_q.addr_sel;
    assign mem_cmd   = ctrl_q.mem_cmd;
    assign halted    = ctrl_q.halted;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_cpu_ctrl_fsm
//
// Directed bench for cpu_ctrl_fsm. Outputs are sampled on the falling edge,
// half a cycle after the state change. Each instruction is traced from IF1
// to the next IF1 into tr[], index 0 being IF1, 1 IF2, 2 UPC, 3 DEC, 4.. the
// execute states; the scenario tasks compare that trace with hand-computed
// expectations.
// -----------------------------------------------------------------------------
module tb_cpu_ctrl_fsm;

    logic       clk;
    logic       reset_n;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic       load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;
    logic [1:0] mem_cmd;

    int n_pass  = 0;
    int n_total = 0;

    cpu_ctrl_fsm dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .op(op),
        .nsel(nsel), .vsel(vsel), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .load_ir(load_ir), .load_pc(load_pc),
        .reset_pc(reset_pc), .load_addr(load_addr), .addr_sel(addr_sel),
        .mem_cmd(mem_cmd), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] nsel;
        logic [3:0] vsel;
        logic       write, loada, loadb, loadc, loads, asel, bsel;
        logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } obs_t;

    obs_t tr[0:30];
    int   n_tr;

    function automatic obs_t sample();
        obs_t o;
        o.nsel = nsel; o.vsel = vsel; o.write = write;
        o.loada = loada; o.loadb = loadb; o.loadc = loadc; o.loads = loads;
        o.asel = asel; o.bsel = bsel; o.load_ir = load_ir;
        o.load_pc = load_pc; o.reset_pc = reset_pc;
        o.load_addr = load_addr; o.addr_sel = addr_sel;
        o.mem_cmd = mem_cmd; o.halted = halted;
        return o;
    endfunction

    function automatic logic at_if1();
        return addr_sel && (mem_cmd == 2'b01) && !load_ir;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse reset across one rising edge; returns sampled in IF1.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Called while sampled in IF1. cyc = cycles back to IF1, -1 if none in 30.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o,
                             output int cyc);
        opcode = opc;
        op     = o;
        tr[0]  = sample();
        cyc    = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (at_if1()) begin
                cyc = i;
                break;
            end
            tr[i] = sample();
        end
        n_tr = (cyc < 0) ? 31 : cyc;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        opcode  = 3'b000;
        op      = 2'b00;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({reset_pc, load_pc, write, mem_cmd, nsel, vsel, halted}
            !== {1'b1, 1'b1, 1'b0, 2'b00, 3'b001, 4'b0001, 1'b0}) begin
            $display("FAIL reset_state: got rpc=%b lpc=%b wr=%b mem=%b nsel=%b vsel=%b h=%b",
                     reset_pc, load_pc, write, mem_cmd, nsel, vsel, halted);
        end else n_pass++;
        @(negedge clk);
        n_total++;
        if ({reset_pc, load_pc} !== 2'b11) begin
            $display("FAIL reset_held: rpc=%b lpc=%b expected 1 1", reset_pc, load_pc);
        end else n_pass++;
        reset_n = 1'b1;
        step();
        n_total++;
        if ({addr_sel, mem_cmd, load_pc, reset_pc} !== {1'b1, 2'b01, 1'b0, 1'b0}) begin
            $display("FAIL reset_to_if1: addr_sel=%b mem=%b lpc=%b rpc=%b expected 1 01 0 0",
                     addr_sel, mem_cmd, load_pc, reset_pc);
        end else n_pass++;
    endtask

    task automatic test_movi();
        int cyc;
        int npc;
        run_instr(3'b110, 2'b10, cyc);
        n_total++;
        if (cyc !== 5) $display("FAIL movi_cycles: got %0d expected 5", cyc);
        else n_pass++;
        n_total++;
        if ({tr[4].write, tr[4].nsel, tr[4].vsel} !== {1'b1, 3'b001, 4'b0100})
            $display("FAIL movi_wimm: wr=%b nsel=%b vsel=%b expected 1 001 0100",
                     tr[4].write, tr[4].nsel, tr[4].vsel);
        else n_pass++;
        npc = 0;
        for (int i = 0; i < n_tr; i++) if (tr[i].load_pc) npc++;
        n_total++;
        if (npc !== 1) $display("FAIL movi_load_pc_count: got %0d expected 1", npc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int nls;
        int nwr;
        run_instr(3'b101, 2'b00, cyc);
        n_total++;
        if (cyc !== 8) $display("FAIL add_cycles: got %0d expected 8", cyc);
        else n_pass++;
        n_total++;
        if ({tr[4].loada, tr[4].nsel, tr[5].loadb, tr[5].nsel, tr[6].loadc, tr[6].asel}
            !== {1'b1, 3'b001, 1'b1, 3'b100, 1'b1, 1'b0})
            $display("FAIL add_operands: GA la=%b n=%b GB lb=%b n=%b ALU lc=%b as=%b",
                     tr[4].loada, tr[4].nsel, tr[5].loadb, tr[5].nsel,
                     tr[6].loadc, tr[6].asel);
        else n_pass++;
        n_total++;
        if ({tr[7].nsel, tr[7].vsel, tr[7].write} !== {3'b010, 4'b0001, 1'b1})
            $display("FAIL add_wrd: nsel=%b vsel=%b wr=%b expected 010 0001 1",
                     tr[7].nsel, tr[7].vsel, tr[7].write);
        else n_pass++;
        run_instr(3'b101, 2'b01, cyc);
        n_total++;
        if (cyc !== 7) $display("FAIL cmp_cycles: got %0d expected 7", cyc);
        else n_pass++;
        nls = 0;
        nwr = 0;
        for (int i = 0; i < n_tr; i++) begin
            if (tr[i].loads) nls++;
            if (tr[i].write) nwr++;
        end
        n_total++;
        if ((nls !== 1) || (nwr !== 0) || (tr[6].loads !== 1'b1))
            $display("FAIL cmp_loads_write: loads=%0d write=%0d expected 1 0", nls, nwr);
        else n_pass++;
    endtask

    task automatic test_ldr();
        int cyc;
        run_instr(3'b011, 2'b00, cyc);
        n_total++;
        if (cyc !== 9) $display("FAIL ldr_cycles: got %0d expected 9", cyc);
        else n_pass++;
        n_total++;
        if ({tr[5].bsel, tr[5].loadc, tr[6].load_addr, tr[7].mem_cmd, tr[7].addr_sel}
            !== {1'b1, 1'b1, 1'b1, 2'b01, 1'b0})
            $display("FAIL ldr_addr_path: bsel=%b lc=%b la=%b mrd_mem=%b mrd_as=%b",
                     tr[5].bsel, tr[5].loadc, tr[6].load_addr,
                     tr[7].mem_cmd, tr[7].addr_sel);
        else n_pass++;
        n_total++;
        if ({tr[8].vsel, tr[8].write, tr[8].nsel, tr[8].mem_cmd}
            !== {4'b1000, 1'b1, 3'b010, 2'b01})
            $display("FAIL ldr_wmem: vsel=%b wr=%b nsel=%b mem=%b expected 1000 1 010 01",
                     tr[8].vsel, tr[8].write, tr[8].nsel, tr[8].mem_cmd);
        else n_pass++;
    endtask

    task automatic test_str();
        int cyc;
        int nwr;
        run_instr(3'b100, 2'b00, cyc);
        n_total++;
        if (cyc !== 10) $display("FAIL str_cycles: got %0d expected 10", cyc);
        else n_pass++;
        n_total++;
        if ({tr[7].nsel, tr[7].loadb, tr[8].asel, tr[8].loadc}
            !== {3'b010, 1'b1, 1'b1, 1'b1})
            $display("FAIL str_gbd_pass: nsel=%b lb=%b asel=%b lc=%b expected 010 1 1 1",
                     tr[7].nsel, tr[7].loadb, tr[8].asel, tr[8].loadc);
        else n_pass++;
        nwr = 0;
        for (int i = 0; i < n_tr; i++) if (tr[i].mem_cmd == 2'b10) nwr++;
        n_total++;
        if ((nwr !== 1) || (tr[9].mem_cmd !== 2'b10) || (tr[9].write !== 1'b0))
            $display("FAIL str_mwr: mem_write cycles=%0d mwr_mem=%b mwr_wr=%b expected 1 10 0",
                     nwr, tr[9].mem_cmd, tr[9].write);
        else n_pass++;
    endtask

    task automatic test_mov_mvn_nop();
        int cyc;
        run_instr(3'b110, 2'b00, cyc);
        n_total++;
        if ((cyc !== 7) || (tr[5].asel !== 1'b1) || (tr[5].loadc !== 1'b1))
            $display("FAIL mov_alum: cycles=%0d asel=%b lc=%b expected 7 1 1",
                     cyc, tr[5].asel, tr[5].loadc);
        else n_pass++;
        run_instr(3'b000, 2'b00, cyc);
        n_total++;
        if (cyc !== 4) $display("FAIL nop_cycles: got %0d expected 4", cyc);
        else n_pass++;
    endtask

    task automatic test_halt();
        int bad;
        opcode = 3'b111;
        op     = 2'b01;
        for (int i = 0; i < 4; i++) step();
        n_total++;
        if (halted !== 1'b1) $display("FAIL halt_entry: halted=%b expected 1", halted);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sample() !== {3'b001, 4'b0001, 12'd0, 2'b00, 1'b1}) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL halt_hold: bad cycles=%0d expected 0", bad);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({halted, reset_pc, load_pc} !== 3'b011)
            $display("FAIL halt_async_reset: h=%b rpc=%b lpc=%b expected 0 1 1",
                     halted, reset_pc, load_pc);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        n_total++;
        if (!at_if1() || (halted !== 1'b0))
            $display("FAIL halt_release_if1: addr_sel=%b mem=%b h=%b expected 1 01 0",
                     addr_sel, mem_cmd, halted);
        else n_pass++;
    endtask

    task automatic test_reset_in_mwr();
        opcode = 3'b100;
        op     = 2'b00;
        for (int i = 0; i < 9; i++) step();
        n_total++;
        if (mem_cmd !== 2'b10) $display("FAIL mwr_reach: mem=%b expected 10", mem_cmd);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({mem_cmd, write, reset_pc, load_pc} !== {2'b00, 1'b0, 1'b1, 1'b1})
            $display("FAIL mwr_async_reset: mem=%b wr=%b rpc=%b lpc=%b expected 00 0 1 1",
                     mem_cmd, write, reset_pc, load_pc);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        n_total++;
        if (!at_if1()) $display("FAIL mwr_release_if1: addr_sel=%b mem=%b", addr_sel, mem_cmd);
        else n_pass++;
    endtask

    function automatic int exp_cycles(input logic [4:0] code);
        case (code)
            5'b110_10: return 5;
            5'b110_00: return 7;
            5'b101_00: return 8;
            5'b101_01: return 7;
            5'b101_10: return 8;
            5'b101_11: return 7;
            5'b011_00: return 9;
            5'b100_00: return 10;
            default:   return (code[4:2] == 3'b111) ? -1 : 4;
        endcase
    endfunction

    task automatic test_all_codes();
        int          cyc;
        int          bad;
        logic [4:0]  code;
        for (int c = 0; c < 32; c++) begin
            code = c[4:0];
            run_instr(code[4:2], code[1:0], cyc);
            n_total++;
            if (cyc !== exp_cycles(code))
                $display("FAIL code_cycles_%b: got %0d expected %0d",
                         code, cyc, exp_cycles(code));
            else n_pass++;
            bad = 0;
            for (int i = 0; i < n_tr; i++) begin
                if (!$onehot(tr[i].nsel) || !$onehot(tr[i].vsel)) bad++;
                if (tr[i].write && (tr[i].mem_cmd == 2'b10)) bad++;
            end
            n_total++;
            if (bad !== 0) $display("FAIL code_onehot_%b: violations=%0d expected 0", code, bad);
            else n_pass++;
            if (cyc < 0) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_movi();
        test_back_to_back();
        test_ldr();
        test_str();
        test_mov_mvn_nop();
        test_halt();
        test_reset_in_mwr();
        test_all_codes();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
